// File: rtl/forward_scoreboard.sv
// forward_scoreboard
//   Operand-forwarding select and long-latency scoreboard for an EXE stage.
//   For each source operand it picks the youngest pipeline stage writing
//   that register, and it requests a stall on a load-use hazard or on a
//   read of a register still owned by an in-flight long-latency operation.
//   Long-latency ops are tracked per register by a busy bit and a countdown.
//   On retirement the op produces a one-cycle completion pulse.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   src_addr      : NUM_SRC packed source register addresses
//   src_used      : per-source "operand is read" flag
//   stg_wr        : per-stage register-write flag (index 0 = youngest)
//   stg_dst       : per-stage destination addresses
//   stg_rdy       : per-stage result-available flag
//   iss_valid     : long-latency issue request
//   iss_dst       : issue destination register
//   iss_lat       : issue latency in cycles (0 treated as 1)
//   flush         : cancel all pending long-latency entries
//   fwd_sel       : per-source select, 0 = register file, k+1 = stage k
//   stall         : EXE hold request
//   iss_ready     : issue accepted this cycle
//   cmpl_valid    : one-cycle retire pulse
//   cmpl_dst      : lowest retiring register address
//   stall_cnt     : saturating count of stalled cycles
module forward_scoreboard #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LAT_W   = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC*ADDR_W-1:0]               src_addr,
  input  logic [NUM_SRC-1:0]                      src_used,
  input  logic [NUM_STG-1:0]                      stg_wr,
  input  logic [NUM_STG*ADDR_W-1:0]               stg_dst,
  input  logic [NUM_STG-1:0]                      stg_rdy,
  input  logic                                    iss_valid,
  input  logic [ADDR_W-1:0]                       iss_dst,
  input  logic [LAT_W-1:0]                        iss_lat,
  input  logic                                    flush,
  output logic [NUM_SRC*$clog2(NUM_STG+1)-1:0]    fwd_sel,
  output logic                                    stall,
  output logic                                    iss_ready,
  output logic                                    cmpl_valid,
  output logic [ADDR_W-1:0]                       cmpl_dst,
  output logic [31:0]                             stall_cnt
);

  localparam int unsigned SEL_W = $clog2(NUM_STG + 1);
  localparam int unsigned NREG  = 2 ** ADDR_W;

  logic [NREG-1:0]            busy_q, busy_d;
  logic [NREG-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]            retire;
  logic                       cmpl_valid_q, cmpl_valid_d;
  logic [ADDR_W-1:0]          cmpl_dst_q, cmpl_dst_d;
  logic [31:0]                stall_cnt_q;

  logic [NUM_SRC-1:0][SEL_W-1:0] sel;
  logic [NUM_SRC-1:0]            ld_haz;
  logic [NUM_SRC-1:0]            sb_haz;

  // Forwarding select and hazard detection
  always_comb begin
    sel    = '0;
    ld_haz = '0;
    sb_haz = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (src_used[s] && (src_addr[s*ADDR_W +: ADDR_W] != '0)) begin
        // Walk from oldest to youngest so the lowest matching stage wins.
        for (int unsigned k = NUM_STG; k > 0; k--) begin
          if (stg_wr[k-1] &&
              (stg_dst[(k-1)*ADDR_W +: ADDR_W] == src_addr[s*ADDR_W +: ADDR_W])) begin
            sel[s]    = SEL_W'(k);
            ld_haz[s] = ~stg_rdy[k-1];
          end
        end
        sb_haz[s] = busy_q[src_addr[s*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign fwd_sel = sel;
  assign stall   = (|ld_haz) | (|sb_haz);

  // Scoreboard next state
  assign iss_ready = iss_valid & ~busy_q[iss_dst] & ~flush;

  always_comb begin
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    retire       = '0;
    cmpl_valid_d = 1'b0;
    cmpl_dst_d   = '0;

    for (int unsigned r = 1; r < NREG; r++) begin
      if (busy_q[r]) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
        if (cnt_q[r] == LAT_W'(1)) begin
          busy_d[r] = 1'b0;
          retire[r] = 1'b1;
        end
      end
    end

    // iss_ready already excludes busy destinations, so an issue never
    // overlaps an entry that is retiring on this edge.
    if (iss_ready && (iss_dst != '0)) begin
      busy_d[iss_dst] = 1'b1;
      cnt_d[iss_dst]  = (iss_lat == '0) ? LAT_W'(1) : iss_lat;
    end

    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
      retire = '0;
    end

    for (int unsigned r = NREG - 1; r > 0; r--) begin
      if (retire[r]) begin
        cmpl_valid_d = 1'b1;
        cmpl_dst_d   = ADDR_W'(r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      cnt_q        <= '0;
      cmpl_valid_q <= 1'b0;
      cmpl_dst_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_dst_q   <= cmpl_dst_d;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign cmpl_valid = cmpl_valid_q;
  assign cmpl_dst   = cmpl_dst_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb_forward_scoreboard
//   Scoreboard bench for forward_scoreboard. A driver applies directed and
//   random stimulus each cycle, computes the expected outputs from a
//   timestamp model (each register remembers the cycle its completion
//   pulse is due) and queues them; a monitor pops and compares on the
//   falling edge.
module tb_forward_scoreboard;

  localparam int NS = 2;
  localparam int NG = 2;
  localparam int AW = 5;
  localparam int LW = 6;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NS*AW-1:0]  src_addr;
  logic [NS-1:0]     src_used;
  logic [NG-1:0]     stg_wr;
  logic [NG*AW-1:0]  stg_dst;
  logic [NG-1:0]     stg_rdy;
  logic              iss_valid;
  logic [AW-1:0]     iss_dst;
  logic [LW-1:0]     iss_lat;
  logic              flush;
  logic [NS*SW-1:0]  fwd_sel;
  logic              stall;
  logic              iss_ready;
  logic              cmpl_valid;
  logic [AW-1:0]     cmpl_dst;
  logic [31:0]       stall_cnt;

  forward_scoreboard #(
    .NUM_SRC(NS),
    .NUM_STG(NG),
    .ADDR_W (AW),
    .LAT_W  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_addr  (src_addr),
    .src_used  (src_used),
    .stg_wr    (stg_wr),
    .stg_dst   (stg_dst),
    .stg_rdy   (stg_rdy),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .iss_lat   (iss_lat),
    .flush     (flush),
    .fwd_sel   (fwd_sel),
    .stall     (stall),
    .iss_ready (iss_ready),
    .cmpl_valid(cmpl_valid),
    .cmpl_dst  (cmpl_dst),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    int          cyc;
    logic [NS*SW-1:0] fwd;
    logic        stall;
    logic        rdy;
    logic        cv;
    logic [AW-1:0] cd;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc;
  int          done_at[32];   // cycle in which the completion pulse shows
  logic [31:0] exp_cnt;

  function automatic void chk(string nm, int c, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, c, act, req);
    end
  endfunction

  // Monitor
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        me = expq.pop_front();
        chk("fwd_sel",    me.cyc, 32'(fwd_sel),    32'(me.fwd));
        chk("stall",      me.cyc, 32'(stall),      32'(me.stall));
        chk("iss_ready",  me.cyc, 32'(iss_ready),  32'(me.rdy));
        chk("cmpl_valid", me.cyc, 32'(cmpl_valid), 32'(me.cv));
        if (me.cv) chk("cmpl_dst", me.cyc, 32'(cmpl_dst), 32'(me.cd));
        chk("stall_cnt",  me.cyc, stall_cnt,       me.cnt);
      end
    end
  end

  task automatic idle();
    rst = 1'b0; src_addr = '0; src_used = '0; stg_wr = '0; stg_dst = '0;
    stg_rdy = '1; iss_valid = 1'b0; iss_dst = '0; iss_lat = '0; flush = 1'b0;
  endtask

  // Predict this cycle's outputs, queue them, advance the model over the
  // coming edge, then move to just after that edge.
  task automatic tick();
    exp_t e;
    int   sel;
    int   a;
    bit   st;
    int   lat;
    e.cyc = cyc;
    e.fwd = '0;
    st    = 1'b0;
    for (int s = 0; s < NS; s++) begin
      a   = int'(src_addr[s*AW +: AW]);
      sel = 0;
      if (src_used[s] && a != 0) begin
        for (int k = 0; k < NG; k++)
          if (sel == 0 && stg_wr[k] && int'(stg_dst[k*AW +: AW]) == a) sel = k + 1;
        if (sel != 0 && !stg_rdy[sel-1]) st = 1'b1;
        if (done_at[a] > cyc) st = 1'b1;
      end
      e.fwd[s*SW +: SW] = SW'(sel);
    end
    e.stall = st;
    e.rdy   = iss_valid && !(done_at[int'(iss_dst)] > cyc) && !flush;
    e.cv    = 1'b0;
    e.cd    = '0;
    for (int r = 31; r >= 1; r--)
      if (done_at[r] == cyc) begin e.cv = 1'b1; e.cd = AW'(r); end
    e.cnt = exp_cnt;
    expq.push_back(e);

    if (rst) begin
      for (int r = 0; r < 32; r++) done_at[r] = 0;
      exp_cnt = '0;
    end else begin
      if (st && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      if (flush) begin
        for (int r = 0; r < 32; r++) if (done_at[r] > cyc) done_at[r] = 0;
      end else if (e.rdy && iss_dst != '0) begin
        lat = (iss_lat == '0) ? 1 : int'(iss_lat);
        done_at[int'(iss_dst)] = cyc + lat + 1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input int d, input int l);
    iss_valid = 1'b1; iss_dst = AW'(d); iss_lat = LW'(l);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
    for (int r = 0; r < 32; r++) done_at[r] = 0;
    exp_cnt = '0;

    // Reset state with idle inputs
    tick();

    // Priority forwarding
    src_addr = {5'd0, 5'd5}; src_used = 2'b01;
    stg_wr = 2'b11; stg_dst = {5'd5, 5'd5}; stg_rdy = 2'b11;
    tick();
    stg_wr = 2'b10;
    tick();
    src_addr = {5'd0, 5'd0};
    tick();

    // Load-use
    idle();
    src_addr = {5'd7, 5'd0}; src_used = 2'b10;
    stg_wr = 2'b01; stg_dst = {5'd0, 5'd7}; stg_rdy = 2'b00;
    tick();
    stg_rdy = 2'b01;
    tick();

    // Latency: dst 9 lat 3, observed through a reader of r9
    idle();
    issue(9, 3);
    tick();
    idle();
    src_addr = {5'd0, 5'd9}; src_used = 2'b01;
    ticks(5);
    idle();
    issue(10, 0);
    tick();
    idle();
    ticks(3);

    // WAW / retire collision: re-issue while count is 1, then hold it
    issue(9, 3);
    tick();
    idle();
    ticks(2);
    issue(9, 2);
    tick();
    tick();
    idle();
    ticks(4);

    // Flush with two entries pending and a simultaneous issue
    issue(3, 5);
    tick();
    issue(4, 6);
    tick();
    issue(5, 2);
    flush = 1'b1;
    tick();
    idle();
    src_addr = {5'd4, 5'd3}; src_used = 2'b11;
    ticks(8);

    // Reset mid-operation
    idle();
    issue(6, 10);
    tick();
    issue(7, 10);
    tick();
    idle();
    src_addr = {5'd7, 5'd6}; src_used = 2'b11;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(2);
    idle();
    tick();

    // Saturation: preload the counter close to its limit, then stall
    dut.stall_cnt_q = 32'hFFFF_FFFD;
    exp_cnt = 32'hFFFF_FFFD;
    src_addr = {5'd7, 5'd0}; src_used = 2'b10;
    stg_wr = 2'b01; stg_dst = {5'd0, 5'd7}; stg_rdy = 2'b00;
    ticks(6);
    flush = 1'b1;
    tick();
    idle();
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      src_addr  = {AW'($urandom_range(7)), AW'($urandom_range(7))};
      src_used  = NS'($urandom_range(3));
      stg_wr    = NG'($urandom_range(3));
      stg_dst   = {AW'($urandom_range(7)), AW'($urandom_range(7))};
      stg_rdy   = ($urandom_range(3) == 0) ? NG'($urandom_range(3)) : '1;
      iss_valid = ($urandom_range(1) == 1);
      iss_dst   = AW'($urandom_range(7));
      iss_lat   = LW'($urandom_range(5));
      flush     = ($urandom_range(15) == 0);
      rst       = ($urandom_range(99) == 0);
      tick();
    end
    idle();
    ticks(20);

    #20;
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
